// File: rtl/dmc_fetch_scheduler.sv
// DMC sample fetch sequencer: owns $4010-$4013, the one-byte sample buffer,
// the bytes-remaining counter and the DMC IRQ; requests bytes from the DMA controller.
module dmc_fetch_scheduler (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        reg_write,
    input  logic [1:0]  reg_addr,
    input  logic [7:0]  reg_data,
    input  logic        status_write,
    input  logic        dmc_enable,
    input  logic        dmc_ack,
    input  logic [7:0]  data_from_ram,
    input  logic        buf_take,
    output logic        dmc_trigger,
    output logic [15:0] dmc_dma_addr,
    output logic        buf_valid,
    output logic [7:0]  buf_data,
    output logic        irq,
    output logic        active
);

    // state | meaning
    // IDLE  | buffer full or nothing left to fetch
    // REQ   | fetch requested, waiting for dmc_ack
    typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

    state_t      state_q, state_d;
    logic        irq_en_q, irq_en_d;
    logic        loop_q, loop_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  l_q, l_d;
    logic [15:0] addr_q, addr_d;
    logic [11:0] remaining_q, remaining_d;
    logic        buf_valid_q, buf_valid_d;
    logic [7:0]  buf_data_q, buf_data_d;
    logic        irq_q, irq_d;

    logic [15:0] start_addr;
    logic [11:0] length;
    logic [15:0] addr_inc;
    logic [11:0] rem_dec;
    logic        capture;

    assign start_addr = {2'b11, a_q, 6'b000000};
    assign length     = {l_q, 4'b0000} + 12'd1;
    assign addr_inc   = (addr_q == 16'hFFFF) ? 16'h8000 : addr_q + 16'd1;
    assign rem_dec    = remaining_q - 12'd1;

    always_comb begin
        state_d     = state_q;
        irq_en_d    = irq_en_q;
        loop_d      = loop_q;
        a_d         = a_q;
        l_d         = l_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        buf_valid_d = buf_valid_q;
        buf_data_d  = buf_data_q;
        irq_d       = irq_q;
        capture     = 1'b0;

        if (ce) begin
            if (reg_write) begin
                case (reg_addr)
                    2'd0: begin
                        irq_en_d = reg_data[7];
                        loop_d   = reg_data[6];
                    end
                    2'd2:    a_d = reg_data;
                    2'd3:    l_d = reg_data;
                    default: ;
                endcase
            end

            // A disable cancels any in-flight request and drops a same-cycle ack
            if (status_write && !dmc_enable) begin
                remaining_d = 12'd0;
                state_d     = IDLE;
            end else begin
                if (status_write && remaining_q == 12'd0) begin
                    addr_d      = start_addr;
                    remaining_d = length;
                end
                case (state_q)
                    IDLE: begin
                        if (!buf_valid_q && remaining_q != 12'd0)
                            state_d = REQ;
                    end
                    REQ: begin
                        if (dmc_ack) begin
                            capture     = 1'b1;
                            state_d     = IDLE;
                            buf_data_d  = data_from_ram;
                            buf_valid_d = 1'b1;
                            addr_d      = addr_inc;
                            remaining_d = rem_dec;
                            if (rem_dec == 12'd0) begin
                                if (loop_q) begin
                                    addr_d      = start_addr;
                                    remaining_d = length;
                                end else if (irq_en_q) begin
                                    irq_d = 1'b1;
                                end
                            end
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end

            if (buf_take && buf_valid_q && !capture)
                buf_valid_d = 1'b0;

            // Clears are applied last so they win over a same-cycle IRQ set
            if (status_write || (reg_write && reg_addr == 2'd0 && !reg_data[7]))
                irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            irq_en_q    <= 1'b0;
            loop_q      <= 1'b0;
            a_q         <= 8'h00;
            l_q         <= 8'h00;
            addr_q      <= 16'hC000;
            remaining_q <= 12'd0;
            buf_valid_q <= 1'b0;
            buf_data_q  <= 8'h00;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            irq_en_q    <= irq_en_d;
            loop_q      <= loop_d;
            a_q         <= a_d;
            l_q         <= l_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            buf_valid_q <= buf_valid_d;
            buf_data_q  <= buf_data_d;
            irq_q       <= irq_d;
        end
    end

    assign dmc_trigger  = (state_q == REQ);
    assign dmc_dma_addr = addr_q;
    assign buf_valid    = buf_valid_q;
    assign buf_data     = buf_data_q;
    assign irq          = irq_q;
    assign active       = (remaining_q != 12'd0);

endmodule

// File: tb/tb_dmc_fetch_scheduler.sv
// Self-checking bench for dmc_fetch_scheduler: a DMA responder pushes fetched bytes
// into a scoreboard queue which is popped when the sample buffer fills.
module tb_dmc_fetch_scheduler;

    logic        clk = 1'b0;
    logic        reset, ce, reg_write, status_write, dmc_enable, dmc_ack, buf_take;
    logic [1:0]  reg_addr;
    logic [7:0]  reg_data, data_from_ram;
    logic        dmc_trigger, buf_valid, irq, active;
    logic [15:0] dmc_dma_addr;
    logic [7:0]  buf_data;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [7:0] exp_q[$];

    dmc_fetch_scheduler dut (
        .clk(clk), .reset(reset), .ce(ce),
        .reg_write(reg_write), .reg_addr(reg_addr), .reg_data(reg_data),
        .status_write(status_write), .dmc_enable(dmc_enable),
        .dmc_ack(dmc_ack), .data_from_ram(data_from_ram), .buf_take(buf_take),
        .dmc_trigger(dmc_trigger), .dmc_dma_addr(dmc_dma_addr),
        .buf_valid(buf_valid), .buf_data(buf_data), .irq(irq), .active(active)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required < 1000000", $time);
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
        reg_write = 1'b1; reg_addr = a; reg_data = d;
        cyc();
        reg_write = 1'b0; reg_addr = 2'd0; reg_data = 8'h00;
    endtask

    task automatic wr_status(input logic en);
        status_write = 1'b1; dmc_enable = en;
        cyc();
        status_write = 1'b0; dmc_enable = 1'b0;
    endtask

    task automatic take();
        buf_take = 1'b1;
        cyc();
        buf_take = 1'b0;
    endtask

    // Waits (bounded) for a request, checks its address, acks it and scores the captured byte.
    task automatic serve(input string name, input logic [15:0] exp_addr, input logic [7:0] d,
                         output logic ok);
        int n;
        logic [7:0] e;
        n  = 0;
        ok = 1'b0;
        while (dmc_trigger !== 1'b1 && n < 50) begin
            cyc();
            n++;
        end
        total_cnt++;
        if (dmc_trigger !== 1'b1) begin
            $display("FAIL %s_trigger_timeout: trigger=%b required 1", name, dmc_trigger);
            return;
        end
        pass_cnt++;
        total_cnt++;
        if (dmc_dma_addr !== exp_addr)
            $display("FAIL %s_addr: got %h required %h", name, dmc_dma_addr, exp_addr);
        else pass_cnt++;
        exp_q.push_back(d);
        dmc_ack = 1'b1; data_from_ram = d;
        cyc();
        dmc_ack = 1'b0; data_from_ram = 8'h00;
        ok = 1'b1;
        total_cnt++;
        if (dmc_trigger !== 1'b0)
            $display("FAIL %s_trigger_drop: got %b required 0", name, dmc_trigger);
        else pass_cnt++;
        e = exp_q.pop_front();
        total_cnt++;
        if (buf_valid !== 1'b1 || buf_data !== e)
            $display("FAIL %s_buf: valid=%b data=%h required valid=1 data=%h", name, buf_valid, buf_data, e);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        total_cnt++;
        if ({dmc_trigger, dmc_dma_addr, buf_valid, buf_data, irq, active} !==
            {1'b0, 16'hC000, 1'b0, 8'h00, 1'b0, 1'b0})
            $display("FAIL reset_outputs: trig=%b addr=%h bv=%b bd=%h irq=%b act=%b required 0 c000 0 00 0 0",
                     dmc_trigger, dmc_dma_addr, buf_valid, buf_data, irq, active);
        else pass_cnt++;
    endtask

    task automatic test_single();
        logic ok, seen;
        wr_reg(2'd0, 8'h80); wr_reg(2'd2, 8'h00); wr_reg(2'd3, 8'h00);
        wr_status(1'b1);
        total_cnt++;
        if (dmc_trigger !== 1'b0 || active !== 1'b1)
            $display("FAIL single_latency_n: trig=%b act=%b required 0 1", dmc_trigger, active);
        else pass_cnt++;
        cyc();
        total_cnt++;
        if (dmc_trigger !== 1'b1)
            $display("FAIL single_latency_n1: trig=%b required 1", dmc_trigger);
        else pass_cnt++;
        serve("single", 16'hC000, 8'h5A, ok);
        total_cnt++;
        if (active !== 1'b0 || irq !== 1'b1)
            $display("FAIL single_end: act=%b irq=%b required 0 1", active, irq);
        else pass_cnt++;
        seen = 1'b0;
        repeat (6) begin cyc(); if (dmc_trigger !== 1'b0) seen = 1'b1; end
        total_cnt++;
        if (seen) $display("FAIL single_no_more: trigger seen=1 required 0");
        else pass_cnt++;
        wr_reg(2'd0, 8'h00);
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL irq_clear_4010: irq=%b required 0", irq);
        else pass_cnt++;
        take();
        total_cnt++;
        if (buf_valid !== 1'b0) $display("FAIL single_take: buf_valid=%b required 0", buf_valid);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        logic ok, seen;
        logic [15:0] ea;
        int acks;
        acks = 0;
        wr_reg(2'd0, 8'h00); wr_reg(2'd2, 8'hFF); wr_reg(2'd3, 8'h04);
        wr_status(1'b1);
        for (int i = 0; i < 65; i++) begin
            ea = (i < 64) ? 16'hFFC0 + 16'(i) : 16'h8000;
            serve("wrap", ea, 8'(i * 3 + 1), ok);
            if (ok) acks++;
            take();
        end
        total_cnt++;
        if (acks != 65) $display("FAIL wrap_acks: got %0d required 65", acks);
        else pass_cnt++;
        total_cnt++;
        if (active !== 1'b0 || irq !== 1'b0 || dmc_dma_addr !== 16'h8001)
            $display("FAIL wrap_end: act=%b irq=%b addr=%h required 0 0 8001", active, irq, dmc_dma_addr);
        else pass_cnt++;
        seen = 1'b0;
        repeat (8) begin cyc(); if (dmc_trigger !== 1'b0) seen = 1'b1; end
        total_cnt++;
        if (seen) $display("FAIL wrap_no_extra: trigger seen=1 required 0");
        else pass_cnt++;
    endtask

    task automatic test_loop();
        logic ok;
        wr_reg(2'd0, 8'hC0); wr_reg(2'd2, 8'h01); wr_reg(2'd3, 8'h00);
        wr_status(1'b1);
        for (int i = 0; i < 4; i++) begin
            serve("loop", 16'hC040, 8'hA0 + 8'(i), ok);
            total_cnt++;
            if (active !== 1'b1 || irq !== 1'b0)
                $display("FAIL loop_state: act=%b irq=%b required 1 0", active, irq);
            else pass_cnt++;
            take();
        end
        wr_status(1'b0);
        total_cnt++;
        if (active !== 1'b0 || dmc_trigger !== 1'b0)
            $display("FAIL loop_disable: act=%b trig=%b required 0 0", active, dmc_trigger);
        else pass_cnt++;
        wr_reg(2'd0, 8'h00);
    endtask

    task automatic test_backpressure();
        logic ok, seen;
        wr_reg(2'd2, 8'h02); wr_reg(2'd3, 8'h01);
        wr_status(1'b1);
        serve("bp", 16'hC080, 8'h33, ok);
        seen = 1'b0;
        repeat (8) begin cyc(); if (dmc_trigger !== 1'b0) seen = 1'b1; end
        total_cnt++;
        if (seen) $display("FAIL bp_hold: trigger seen=1 required 0");
        else pass_cnt++;
        take();
        total_cnt++;
        if (dmc_trigger !== 1'b0) $display("FAIL bp_take_edge: trig=%b required 0", dmc_trigger);
        else pass_cnt++;
        cyc();
        total_cnt++;
        if (dmc_trigger !== 1'b1 || dmc_dma_addr !== 16'hC081)
            $display("FAIL bp_rearm: trig=%b addr=%h required 1 c081", dmc_trigger, dmc_dma_addr);
        else pass_cnt++;
    endtask

    task automatic test_disable_ack();
        logic seen;
        status_write = 1'b1; dmc_enable = 1'b0; dmc_ack = 1'b1; data_from_ram = 8'h77;
        cyc();
        status_write = 1'b0; dmc_ack = 1'b0; data_from_ram = 8'h00;
        total_cnt++;
        if ({dmc_trigger, buf_valid, active, dmc_dma_addr} !== {1'b0, 1'b0, 1'b0, 16'hC081})
            $display("FAIL disable_ack: trig=%b bv=%b act=%b addr=%h required 0 0 0 c081",
                     dmc_trigger, buf_valid, active, dmc_dma_addr);
        else pass_cnt++;
        seen = 1'b0;
        repeat (4) begin cyc(); if (dmc_trigger !== 1'b0) seen = 1'b1; end
        total_cnt++;
        if (seen) $display("FAIL disable_quiet: trigger seen=1 required 0");
        else pass_cnt++;
    endtask

    task automatic test_ce_hold();
        logic ok;
        wr_reg(2'd2, 8'h03); wr_reg(2'd3, 8'h00);
        wr_status(1'b1);
        cyc();
        ce = 1'b0; dmc_ack = 1'b1; data_from_ram = 8'hEE;
        repeat (3) cyc();
        total_cnt++;
        if ({dmc_trigger, buf_valid, active, dmc_dma_addr} !== {1'b1, 1'b0, 1'b1, 16'hC0C0})
            $display("FAIL ce_hold: trig=%b bv=%b act=%b addr=%h required 1 0 1 c0c0",
                     dmc_trigger, buf_valid, active, dmc_dma_addr);
        else pass_cnt++;
        dmc_ack = 1'b0; data_from_ram = 8'h00; ce = 1'b1;
        serve("ce", 16'hC0C0, 8'h42, ok);
        total_cnt++;
        if (active !== 1'b0) $display("FAIL ce_end: act=%b required 0", active);
        else pass_cnt++;
        take();
    endtask

    task automatic test_irq_status();
        logic ok;
        wr_reg(2'd0, 8'h80); wr_reg(2'd2, 8'h00); wr_reg(2'd3, 8'h00);
        wr_status(1'b1);
        serve("irq", 16'hC000, 8'h11, ok);
        total_cnt++;
        if (irq !== 1'b1) $display("FAIL irq_set: irq=%b required 1", irq);
        else pass_cnt++;
        wr_status(1'b0);
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL irq_clear_status: irq=%b required 0", irq);
        else pass_cnt++;
        take();
    endtask

    task automatic test_reset_mid_req();
        logic ok;
        wr_reg(2'd0, 8'hC0); wr_reg(2'd2, 8'h10); wr_reg(2'd3, 8'h02);
        wr_status(1'b1);
        serve("pre_reset", 16'hC400, 8'h99, ok);
        take();
        cyc();
        total_cnt++;
        if (dmc_trigger !== 1'b1) $display("FAIL pre_reset_req: trig=%b required 1", dmc_trigger);
        else pass_cnt++;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        total_cnt++;
        if ({dmc_trigger, dmc_dma_addr, buf_valid, buf_data, irq, active} !==
            {1'b0, 16'hC000, 1'b0, 8'h00, 1'b0, 1'b0})
            $display("FAIL reset_mid_req: trig=%b addr=%h bv=%b bd=%h irq=%b act=%b required 0 c000 0 00 0 0",
                     dmc_trigger, dmc_dma_addr, buf_valid, buf_data, irq, active);
        else pass_cnt++;
        wr_status(1'b1);
        serve("post_reset", 16'hC000, 8'h5C, ok);
        total_cnt++;
        if (active !== 1'b0 || irq !== 1'b0)
            $display("FAIL post_reset_regs: act=%b irq=%b required 0 0", active, irq);
        else pass_cnt++;
    endtask

    initial begin
        reset = 1'b1; ce = 1'b1; reg_write = 1'b0; reg_addr = 2'd0; reg_data = 8'h00;
        status_write = 1'b0; dmc_enable = 1'b0; dmc_ack = 1'b0; data_from_ram = 8'h00;
        buf_take = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_wrap();
        test_loop();
        test_backpressure();
        test_disable_ack();
        test_ce_hold();
        test_irq_status();
        test_reset_mid_req();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
